// File: rtl/interrupt_timer_pkg.sv
// interrupt_timer_pkg: shared FSM encoding, register offsets, CTRL bit positions and MODE codes.
package interrupt_timer_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_e;
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;
endpackage

// File: rtl/tc_prescaler.sv
// tc_prescaler: emits one tick every PRESCALE cycles while run_i is high; restarts whenever run_i drops.
module tc_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk_in,
    input  logic sys_rstn,
    input  logic run_i,
    output logic tick_o
);
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign tick_o = run_i && cnt_q == W'(PRESCALE - 1);
    assign cnt_d = (!run_i || tick_o) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/interrupt_timer.sv
// interrupt_timer: bus-programmable down-counter raising irq on expiry (one-shot or auto-reload).
// Define TC_PRESCALER_EN to slow COUNT decrements to one per PRESCALE cycles.
module interrupt_timer
    import interrupt_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk_in,
    input  logic        sys_rstn,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d, count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        tick, wr_ctrl, wr_preset;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be at least 1");
    end

`ifdef TC_PRESCALER_EN
    tc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk_in  (clk_in),
        .sys_rstn(sys_rstn),
        .run_i   (state_q == ST_CNT),
        .tick_o  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign wr_ctrl   = we && addr == OFF_CTRL && byteen[0];
    assign wr_preset = we && addr == OFF_PRESET;
    assign irq       = irq_flag_q & ctrl_q[CTRL_IM];

    always_comb begin
        rdata = addr == OFF_CTRL   ? {28'd0, ctrl_q} :
                addr == OFF_PRESET ? preset_q :
                addr == OFF_COUNT  ? count_q : '0;
    end

    always_comb begin
        preset_d = preset_q;
        for (int i = 0; i < 4; i++)
            if (wr_preset && byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
    end

    // A low-byte CTRL write acknowledges the flag only while unmasked, so unmasking a pending interrupt raises irq.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ctrl_d     = wr_ctrl ? wdata[3:0] : ctrl_q;
        irq_flag_d = (wr_ctrl && ctrl_q[CTRL_IM]) ? 1'b0 : irq_flag_q;
        unique case (state_q)
            ST_IDLE: state_d = ctrl_q[CTRL_EN] ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                count_d    = preset_q;
                irq_flag_d = 1'b0;
                state_d    = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) state_d = ST_IDLE;
                else if (count_q == '0) state_d = ST_INT;
                else if (tick) count_d = count_q - 1'b1;
            end
            ST_INT: begin
                irq_flag_d = 1'b1;
                if (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD) state_d = ST_LOAD;
                else begin
                    state_d = ST_IDLE;
                    if (!wr_ctrl) ctrl_d[CTRL_EN] = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end
endmodule

// File: tb/tb_interrupt_timer.sv
// tb_interrupt_timer: scoreboard bench for interrupt_timer in its default (no prescaler) build.
module tb_interrupt_timer;
    logic        clk_in = 1'b0;
    logic        sys_rstn = 1'b0;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    interrupt_timer dut (
        .clk_in  (clk_in),
        .sys_rstn(sys_rstn),
        .addr    (addr),
        .we      (we),
        .byteen  (byteen),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_empty: got %h expected nothing", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic exp_rd(input logic [1:0] a, input logic [31:0] v, input string tag);
        addr = a;
        sb.push_back('{tag, v});
        #1;
        observe(rdata);
    endtask

    task automatic exp_irq(input logic v, input string tag);
        sb.push_back('{tag, {31'd0, v}});
        observe({31'd0, irq});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a;
        wdata = d;
        byteen = be;
        we = 1'b1;
        @(posedge clk_in);
        #1;
        we = 1'b0;
        byteen = '0;
    endtask

    initial begin
        #1;
        exp_rd(0, 0, "rst_ctrl");
        exp_rd(1, 0, "rst_preset");
        exp_rd(2, 0, "rst_count");
        exp_irq(0, "rst_irq");
        sys_rstn = 1'b1;

        wr(0, 32'hFFFF_FFF8, 4'hF);
        exp_rd(0, 32'h8, "ctrl_upper_ignored");
        wr(0, 32'h0000_0001, 4'b1110);
        exp_rd(0, 32'h8, "ctrl_no_byte0");
        wr(1, 32'h1122_3344, 4'hF);
        wr(1, 32'hAABB_CCDD, 4'b0101);
        exp_rd(1, 32'h11BB_33DD, "preset_bytes");
        wr(2, 32'hFFFF_FFFF, 4'hF);
        exp_rd(2, 0, "count_ro");
        wr(3, 32'hFFFF_FFFF, 4'hF);
        exp_rd(3, 0, "reserved_zero");

        // one-shot, PRESET=3: irq at the 7th edge after the CTRL write
        wr(1, 3, 4'hF);
        wr(0, 32'h9, 4'h1);
        addr = 2;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_irq(k >= 7, $sformatf("os_irq_k%0d", k));
            exp_rd(2, k == 1 ? 0 : (k <= 5 ? 5 - k : 0), $sformatf("os_count_k%0d", k));
        end
        exp_rd(0, 32'h8, "os_en_cleared");
        wr(0, 32'h8, 4'h1);
        exp_irq(0, "ack_irq");
        step(3);
        exp_irq(0, "ack_idle_irq");

        // auto-reload, PRESET=2: 5-cycle period
        wr(1, 2, 4'hF);
        wr(0, 32'hB, 4'h1);
        for (int k = 1; k <= 17; k++) begin
            int p;
            step(1);
            p = (k - 2) % 5;
            exp_irq(k >= 6 && (k - 6) % 5 == 0, $sformatf("rl_irq_k%0d", k));
            exp_rd(2, k < 2 ? 0 : (p == 0 ? 2 : (p == 1 ? 1 : 0)), $sformatf("rl_count_k%0d", k));
        end
        wr(0, 32'h0, 4'h1);
        step(3);
        exp_irq(0, "rl_stop_irq");
        exp_rd(2, 1, "rl_count_frozen");

        // PRESET=0 boundary: irq on the 4th edge after the CTRL write
        wr(1, 0, 4'hF);
        wr(0, 32'h9, 4'h1);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            exp_irq(k == 4, $sformatf("z_irq_k%0d", k));
        end
        wr(0, 32'h8, 4'h1);
        exp_irq(0, "z_ack_irq");

        // masked expiry, then unmask
        wr(1, 1, 4'hF);
        wr(0, 32'h1, 4'h1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            exp_irq(0, $sformatf("m_irq_k%0d", k));
        end
        wr(0, 32'h8, 4'h1);
        exp_irq(1, "m_unmask_irq");
        wr(0, 32'h8, 4'h1);
        exp_irq(0, "m_ack_irq");

        // long count, PRESET rewrite mid-count, async reset at COUNT=50
        wr(1, 100, 4'hF);
        wr(0, 32'h9, 4'h1);
        addr = 2;
        step(21);
        exp_rd(2, 81, "long_count81");
        wr(1, 7, 4'hF);
        step(30);
        exp_rd(2, 50, "long_count50");
        exp_rd(1, 7, "long_preset7");
        sys_rstn = 1'b0;
        exp_rd(0, 0, "arst_ctrl");
        exp_rd(1, 0, "arst_preset");
        exp_rd(2, 0, "arst_count");
        exp_irq(0, "arst_irq");
        step(2);
        sys_rstn = 1'b1;
        step(4);
        exp_irq(0, "post_rst_irq");
        exp_rd(2, 0, "post_rst_count");
        exp_rd(0, 0, "post_rst_ctrl");

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/interrupt_timer.md
INTERRUPT_TIMER -- requirements
Module: interrupt_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, cycles per COUNT decrement (used only under TC_PRESCALER_EN).
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port sys_rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port addr  input  2  word offset (bridge-decoded addr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 SHALL have port we  input  1  write strobe from bridge, block selected.
REQ-006 SHALL have port byteen  input  4  per-byte write enables; byte i written only when byteen[i]=1 and we=1.
REQ-007 SHALL have port wdata  input  32  write data.
REQ-008 SHALL have port rdata  output  32  combinational read data of addressed register.
REQ-009 SHALL have port irq  output  1  interrupt request to CPU interrupt input.

Function
REQ-010 CTRL SHALL hold bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] SHALL read 0 and ignore writes.
REQ-011 PRESET SHALL be 32-bit read/write; COUNT SHALL be read-only, writes ignored; offset 3 SHALL read 0.
REQ-012 FSM SHALL have states IDLE, LOAD, CNT, INT.
REQ-013 IDLE: EN=1 -> LOAD next cycle; else stay.
REQ-014 LOAD: COUNT<=PRESET; -> CNT.
REQ-015 CNT: EN=0 -> IDLE with COUNT frozen; COUNT=0 -> INT; else COUNT<=COUNT-1 (per decrement tick).
REQ-016 INT, MODE=0: EN<=0, irq_flag<=1 held, -> IDLE.
REQ-017 INT, MODE=1: irq_flag<=1 for exactly one cycle, -> LOAD (auto-reload).
REQ-018 MODE=2 or 3 SHALL behave as MODE=0.
REQ-019 irq SHALL equal irq_flag AND IM, registered-free from irq_flag.
REQ-020 MODE=0 irq_flag SHALL clear on any CTRL write with byteen[0]=1.
REQ-021 PRESET=0 SHALL give LOAD->CNT->INT: irq at third cycle after EN observed.
REQ-022 PRESET=N SHALL give irq_flag set N+2 cycles after LOAD (PRESCALE=1).
REQ-023 Simultaneous CTRL write and FSM EN clear in INT SHALL let the software write win.
REQ-024 PRESET write while counting SHALL not affect COUNT until next LOAD.
REQ-025 COUNT decrement SHALL not wrap below 0.

Reset
REQ-026 On sys_rstn=0 SHALL immediately: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0, prescaler=0.
REQ-027 Reset mid-count SHALL abort without irq; release SHALL resume in IDLE.

Configuration
REQ-028 Macro TC_PRESCALER_EN defined: COUNT decrements only on tick every PRESCALE cycles in CNT; prescaler clears on LOAD and on leaving CNT.
REQ-029 Macro undefined: tick every CNT cycle; PRESCALE ignored; no prescaler flops synthesized.

Structure
REQ-030 Shared package SHALL hold state encoding, register offsets, CTRL bit positions, MODE codes.
REQ-031 Prescaler SHALL be sub-module tc_prescaler, instantiated only under TC_PRESCALER_EN.

Verification
REQ-032 PRESET=3, CTRL=0x9 (EN,IM,MODE0) -> irq rises 5 cycles after LOAD, stays high; CTRL read shows EN=0.
REQ-033 Then write CTRL=0x8 byteen=0001 -> irq falls next cycle; state IDLE.
REQ-034 PRESET=2, CTRL=0xB (MODE1) -> one-cycle irq pulses every 5 cycles, COUNT reads 2,1,0 repeating.
REQ-035 CTRL=0x1 (IM=0), PRESET=1 -> irq stays 0, internal flag set; write IM=1 -> irq high.
REQ-036 Counting from PRESET=100, sys_rstn low at COUNT=50 -> all registers 0 and irq 0 same cycle.
REQ-037 TC_PRESCALER_EN, PRESCALE=4, PRESET=2 -> COUNT changes every 4 cycles; irq at 4*2+2 cycles after LOAD.
